// File: rtl/dmem_lsu_if.sv
// Handshake bundles for dmem_lsu: pipeline request/response side and data-memory bus side.
// The pipeline is master of dmem_req_if; the LSU is master of dmem_bus_if.

interface dmem_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  dmtype;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] dout;
  logic        fault;

  modport master (
    output req_valid, mem_read, mem_write, dmtype, addr, wdata,
    input  req_ready, stall, rsp_valid, dout, fault
  );
  modport slave (
    input  req_valid, mem_read, mem_write, dmtype, addr, wdata,
    output req_ready, stall, rsp_valid, dout, fault
  );
endinterface

interface dmem_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );
  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: one memory op at a time onto a word-aligned bus with byte enables,
// extended load data back to write-back, with misaligned/illegal/timeout fault reporting.

module dmem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  dmem_req_if.slave   req,
  dmem_bus_if.master  bus
);

  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        req_ready_q, req_ready_d;
  logic        bus_req_q, bus_req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] dout_q, dout_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [2:0]  dmtype_q, dmtype_d;
  logic [1:0]  lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        mem_op;
  logic        illegal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  assign mem_op = req.mem_read | req.mem_write;

  always_comb begin
    illegal = req.mem_read & req.mem_write;
    case (req.dmtype)
      3'b000, 3'b100: ;
      3'b001, 3'b101: if (req.addr[0]) illegal = 1'b1;
      3'b010:         if (req.addr[1:0] != 2'b00) illegal = 1'b1;
      default:        illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (req.dmtype)
      3'b000, 3'b100: be_new = 4'b0001 << req.addr[1:0];
      3'b001, 3'b101: be_new = req.addr[1] ? 4'b1100 : 4'b0011;
      default:        be_new = 4'b1111;
    endcase
    case (req.dmtype[1:0])
      2'b00:   wdata_new = {4{req.wdata[7:0]}};
      2'b01:   wdata_new = {2{req.wdata[15:0]}};
      default: wdata_new = req.wdata;
    endcase
  end

  // Lane selection uses the address captured at accept, not the live request.
  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = bus.bus_rdata[7:0];
      2'd1:    byte_sel = bus.bus_rdata[15:8];
      2'd2:    byte_sel = bus.bus_rdata[23:16];
      default: byte_sel = bus.bus_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (dmtype_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = bus.bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    dout_d      = dout_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    dmtype_d    = dmtype_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req.req_valid && mem_op) begin
          if (illegal) begin
            state_d = S_RESP;
            fault_d = 1'b1;
            dout_d  = '0;
          end else begin
            state_d     = S_BUSY;
            bus_we_d    = req.mem_write;
            bus_addr_d  = {req.addr[31:2], 2'b00};
            bus_be_d    = be_new;
            bus_wdata_d = wdata_new;
            dmtype_d    = req.dmtype;
            lane_d      = req.addr[1:0];
            cnt_d       = '0;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.bus_ack) begin
          state_d = S_RESP;
          fault_d = 1'b0;
          if (!bus_we_q) dout_d = load_val;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          state_d = S_RESP;
          fault_d = 1'b1;
          dout_d  = '0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    bus_req_d   = (state_d == S_BUSY);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      bus_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      dout_q      <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      dmtype_q    <= '0;
      lane_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      bus_req_q   <= bus_req_d;
      rsp_valid_q <= rsp_valid_d;
      fault_q     <= fault_d;
      dout_q      <= dout_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      dmtype_q    <= dmtype_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req.req_ready = req_ready_q;
  assign req.stall     = ((state_q == S_IDLE) & req.req_valid & mem_op) | (state_q == S_BUSY);
  assign req.rsp_valid = rsp_valid_q;
  assign req.dout      = dout_q;
  assign req.fault     = fault_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: vector table of single ops plus hand sequences for
// timeout, reset during BUSY and stray acknowledges.

module tb_dmem_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_req_if rq();
  dmem_bus_if bs();
  dmem_req_if rq_to();
  dmem_bus_if bs_to();

  dmem_lsu u_dut (.clk(clk), .rst(rst), .req(rq), .bus(bs));
  dmem_lsu #(.TIMEOUT(4)) u_to (.clk(clk), .rst(rst), .req(rq_to), .bus(bs_to));

  int total = 0;
  int bad   = 0;
  logic [31:0] model_dout = '0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  dt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned waitc;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic        flt;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL v%0d %s: got %h want %h", idx, name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] exp_dout;
    rq.req_valid = 1'b1;
    rq.mem_read  = v.rd;
    rq.mem_write = v.wr;
    rq.dmtype    = v.dt;
    rq.addr      = v.addr;
    rq.wdata     = v.wdata;
    bs.bus_rdata = v.rdata;
    bs.bus_ack   = 1'b0;
    @(negedge clk);
    chk(idx, "stall_accept", rq.stall, 1);
    chk(idx, "ready_accept", rq.req_ready, 1);
    chk(idx, "rsp_idle", rq.rsp_valid, 0);
    @(posedge clk); #1;
    rq.req_valid = 1'b0;
    rq.mem_read  = 1'b0;
    rq.mem_write = 1'b0;
    if (v.flt) begin
      @(negedge clk);
      chk(idx, "ill_bus_req", bs.bus_req, 0);
      chk(idx, "ill_rsp", rq.rsp_valid, 1);
      chk(idx, "ill_fault", rq.fault, 1);
      chk(idx, "ill_dout", rq.dout, 0);
      chk(idx, "ill_stall", rq.stall, 0);
      model_dout = '0;
    end else begin
      for (int unsigned c = 1; c <= v.waitc + 1; c++) begin
        if (c == v.waitc + 1) bs.bus_ack = 1'b1;
        @(negedge clk);
        chk(idx, "bus_req", bs.bus_req, 1);
        chk(idx, "bus_be", bs.bus_be, v.be);
        chk(idx, "bus_wdata", bs.bus_wdata, v.bwdata);
        chk(idx, "bus_we", bs.bus_we, v.wr);
        chk(idx, "bus_addr", bs.bus_addr, {v.addr[31:2], 2'b00});
        chk(idx, "stall_busy", rq.stall, 1);
        chk(idx, "rsp_busy", rq.rsp_valid, 0);
        @(posedge clk); #1;
      end
      bs.bus_ack = 1'b0;
      exp_dout = v.wr ? model_dout : v.dout;
      @(negedge clk);
      chk(idx, "rsp_valid", rq.rsp_valid, 1);
      chk(idx, "fault", rq.fault, 0);
      chk(idx, "dout", rq.dout, exp_dout);
      chk(idx, "bus_req_after", bs.bus_req, 0);
      chk(idx, "stall_resp", rq.stall, 0);
      chk(idx, "ready_resp", rq.req_ready, 0);
      model_dout = exp_dout;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int hi;
    int rsp_cyc;
    logic seen;

    vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h11223344, 32'hDEADBEEF, 0, 4'b1111, 32'h11223344, 0, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80AB1234, 0, 4'b1000, 32'h0,        0, 32'hFFFFFF80};
    vecs[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80AB1234, 1, 4'b1000, 32'h0,        0, 32'h00000080};
    vecs[3]  = '{0, 1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0,        5, 4'b1100, 32'hBEEFBEEF, 0, 32'h0};
    vecs[4]  = '{1, 0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 1, 4'b1100, 32'h0,        0, 32'hFFFF8001};
    vecs[5]  = '{1, 0, 3'b101, 32'h100, 32'h0,        32'h8001F00D, 0, 4'b0011, 32'h0,        0, 32'h0000F00D};
    vecs[6]  = '{0, 1, 3'b000, 32'h101, 32'h123456A5, 32'h0,        2, 4'b0010, 32'hA5A5A5A5, 0, 32'h0};
    vecs[7]  = '{1, 0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 0, 4'b0010, 32'h0,        0, 32'h0000007F};
    vecs[8]  = '{1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1, 32'h0};
    vecs[9]  = '{1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1, 32'h0};
    vecs[10] = '{1, 0, 3'b001, 32'h103, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1, 32'h0};
    vecs[11] = '{1, 1, 3'b010, 32'h100, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1, 32'h0};
    vecs[12] = '{0, 1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0,        3, 4'b1111, 32'hCAFEF00D, 0, 32'h0};
    vecs[13] = '{1, 0, 3'b100, 32'h102, 32'h0,        32'h00C30000, 0, 4'b0100, 32'h0,        0, 32'h000000C3};
    vecs[14] = '{1, 0, 3'b110, 32'h100, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        1, 32'h0};

    rst = 1'b1;
    rq.req_valid = 0; rq.mem_read = 0; rq.mem_write = 0; rq.dmtype = '0; rq.addr = '0; rq.wdata = '0;
    bs.bus_ack = 0; bs.bus_rdata = '0;
    rq_to.req_valid = 0; rq_to.mem_read = 0; rq_to.mem_write = 0; rq_to.dmtype = '0;
    rq_to.addr = '0; rq_to.wdata = '0;
    bs_to.bus_ack = 0; bs_to.bus_rdata = '0;

    @(negedge clk);
    chk(-1, "rst_ready", rq.req_ready, 1);
    chk(-1, "rst_bus_req", bs.bus_req, 0);
    chk(-1, "rst_dout", rq.dout, 0);
    chk(-1, "rst_fault", rq.fault, 0);
    chk(-1, "rst_rsp", rq.rsp_valid, 0);
    chk(-1, "rst_stall", rq.stall, 0);
    chk(-1, "rst_be", bs.bus_be, 0);
    chk(-1, "rst_to_ready", rq_to.req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Request that is neither load nor store: accepted silently.
    rq.req_valid = 1'b1;
    @(negedge clk);
    chk(-1, "nop_stall", rq.stall, 0);
    chk(-1, "nop_ready", rq.req_ready, 1);
    @(posedge clk); #1;
    rq.req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk(-1, "nop_bus_req", bs.bus_req, 0);
      chk(-1, "nop_rsp", rq.rsp_valid, 0);
      chk(-1, "nop_ready_after", rq.req_ready, 1);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Stray acknowledge while IDLE must not produce a response or touch dout.
    bs.bus_rdata = 32'hFFFFFFFF;
    bs.bus_ack   = 1'b1;
    @(posedge clk); #1;
    bs.bus_ack = 1'b0;
    @(negedge clk);
    chk(-1, "stray_rsp", rq.rsp_valid, 0);
    chk(-1, "stray_dout", rq.dout, model_dout);
    chk(-1, "stray_bus_req", bs.bus_req, 0);
    @(posedge clk); #1;

    // TIMEOUT=4 instance: one good load, then a load that never gets acked.
    rq_to.req_valid = 1; rq_to.mem_read = 1; rq_to.dmtype = 3'b010; rq_to.addr = 32'h40;
    bs_to.bus_rdata = 32'h12345678;
    @(posedge clk); #1;
    rq_to.req_valid = 0; rq_to.mem_read = 0;
    bs_to.bus_ack = 1;
    @(negedge clk);
    chk(-1, "to_first_bus_req", bs_to.bus_req, 1);
    @(posedge clk); #1;
    bs_to.bus_ack = 0;
    @(negedge clk);
    chk(-1, "to_first_rsp", rq_to.rsp_valid, 1);
    chk(-1, "to_first_dout", rq_to.dout, 32'h12345678);
    @(posedge clk); #1;
    rq_to.req_valid = 1; rq_to.mem_read = 1; rq_to.addr = 32'h44;
    @(posedge clk); #1;
    rq_to.req_valid = 0; rq_to.mem_read = 0;
    hi = 0; rsp_cyc = 0; seen = 1'b0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      @(negedge clk);
      if (bs_to.bus_req) hi++;
      if (rq_to.rsp_valid) begin
        seen = 1'b1;
        rsp_cyc = c;
        chk(-1, "to_fault", rq_to.fault, 1);
        chk(-1, "to_dout", rq_to.dout, 0);
        chk(-1, "to_bus_req_resp", bs_to.bus_req, 0);
      end
      @(posedge clk); #1;
    end
    chk(-1, "to_seen", seen, 1);
    chk(-1, "to_req_cycles", hi, 4);
    chk(-1, "to_rsp_cycle", rsp_cyc, 5);

    // Asynchronous reset in the middle of a BUSY transfer.
    rq.req_valid = 1; rq.mem_read = 1; rq.dmtype = 3'b010; rq.addr = 32'h300;
    bs.bus_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    rq.req_valid = 0; rq.mem_read = 0;
    @(negedge clk);
    chk(-1, "rb_bus_req", bs.bus_req, 1);
    #1 rst = 1'b1;
    #1;
    chk(-1, "rb_ready", rq.req_ready, 1);
    chk(-1, "rb_bus_req0", bs.bus_req, 0);
    chk(-1, "rb_dout", rq.dout, 0);
    chk(-1, "rb_fault", rq.fault, 0);
    chk(-1, "rb_rsp", rq.rsp_valid, 0);
    chk(-1, "rb_stall", rq.stall, 0);
    chk(-1, "rb_addr", bs.bus_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bs.bus_ack = 1'b1;
    @(posedge clk); #1;
    bs.bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk(-1, "rb_no_rsp", rq.rsp_valid, 0);
      chk(-1, "rb_no_bus_req", bs.bus_req, 0);
      @(posedge clk); #1;
    end
    model_dout = '0;
    run_vec('{1, 0, 3'b010, 32'h104, 32'h0, 32'h0BADCAFE, 2, 4'b1111, 32'h0, 0, 32'h0BADCAFE}, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
